// File: rtl/data_writeback_cache_controller_pkg.sv
// dcache_pkg: shared FSM state type and cache write-data source selects
package dcache_pkg;
  typedef enum logic [1:0] {READY, WRITEBACK, FILL} dcache_state_t;
  localparam logic CACHE_SRC_CPU = 1'b0;
  localparam logic CACHE_SRC_BUS = 1'b1;
endpackage

// File: rtl/data_writeback_cache_controller_if.sv
// dcache_if: CPU request, cache-way and memory-bus signals; master = controller, slave = environment
interface dcache_if #(parameter int blocksize = 4) ();
  logic MemRE, MemWE, Hit, VictimDirty, BusReady;
  logic Stall, CWE, CacheSrc, DirtyIn, ValidIn, BusRE, BusWE, UseVictimTag, UseCounter;
  logic [$clog2(blocksize)-1:0] WordCount;
  modport master (
    input  MemRE, MemWE, Hit, VictimDirty, BusReady,
    output Stall, CWE, CacheSrc, DirtyIn, ValidIn, BusRE, BusWE, UseVictimTag, UseCounter, WordCount
  );
  modport slave (
    output MemRE, MemWE, Hit, VictimDirty, BusReady,
    input  Stall, CWE, CacheSrc, DirtyIn, ValidIn, BusRE, BusWE, UseVictimTag, UseCounter, WordCount
  );
endinterface

// File: rtl/data_writeback_cache_controller_counter.sv
// block_word_counter: word index within a block transfer; clk/rst, clr_i sync clear, en_i advance, count_o, last_o
module block_word_counter #(
  parameter int blockoffset = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   en_i,
  output logic [blockoffset-1:0] count_o,
  output logic                   last_o
);
  logic [blockoffset-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : en_i ? count_q + blockoffset'(1) : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count_o = count_q;
  assign last_o  = &count_q;
endmodule

// File: rtl/data_writeback_cache_controller.sv
// data_writeback_cache_controller: write-back dcache miss FSM; clk, reset, bus (dcache_if.master: CPU req, way status, memory bus strobes, WordCount)
module data_writeback_cache_controller
  import dcache_pkg::*;
#(
  parameter int blocksize   = 4,
  parameter int blockoffset = $clog2(blocksize)
) (
  input logic      clk,
  input logic      reset,
  dcache_if.master bus
);
  dcache_state_t state_q, state_d;
  logic last, en;
  logic req, miss;
  assign req  = bus.MemRE | bus.MemWE;
  assign miss = req & ~bus.Hit;
  always_ff @(posedge clk) state_q <= reset ? READY : state_d;
  always_comb begin
    state_d          = state_q;
    en               = 1'b0;
    bus.Stall        = 1'b0;
    bus.CWE          = 1'b0;
    bus.CacheSrc     = CACHE_SRC_CPU;
    bus.DirtyIn      = 1'b0;
    bus.ValidIn      = 1'b0;
    bus.BusRE        = 1'b0;
    bus.BusWE        = 1'b0;
    bus.UseVictimTag = 1'b0;
    bus.UseCounter   = 1'b0;
    case (state_q)
      READY: begin
        bus.Stall   = miss;
        bus.CWE     = bus.MemWE & bus.Hit;
        bus.DirtyIn = bus.MemWE & bus.Hit;
        bus.ValidIn = bus.MemWE & bus.Hit;
        state_d     = miss ? (bus.VictimDirty ? WRITEBACK : FILL) : READY;
      end
      WRITEBACK: begin
        bus.Stall        = 1'b1;
        bus.BusWE        = 1'b1;
        bus.UseVictimTag = 1'b1;
        bus.UseCounter   = 1'b1;
        en               = bus.BusReady;
        state_d          = (bus.BusReady & last) ? FILL : WRITEBACK;
      end
      FILL: begin
        bus.Stall      = 1'b1;
        bus.BusRE      = 1'b1;
        bus.UseCounter = 1'b1;
        bus.CWE        = bus.BusReady;
        bus.CacheSrc   = CACHE_SRC_BUS;
        bus.ValidIn    = 1'b1;
        en             = bus.BusReady;
        state_d        = (bus.BusReady & last) ? READY : FILL;
      end
      default: state_d = READY;
    endcase
  end
  // WordCount restarts at 0 on every state change, so each transfer begins at word 0
  block_word_counter #(.blockoffset(blockoffset)) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (state_d != state_q),
    .en_i   (en),
    .count_o(bus.WordCount),
    .last_o (last)
  );
endmodule

// File: tb/tb_data_writeback_cache_controller.sv
// tb_data_writeback_cache_controller: table-driven scoreboard bench for the dcache miss FSM
module tb_data_writeback_cache_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_if #(.blocksize(4)) bus ();
  data_writeback_cache_controller #(.blocksize(4)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );
  typedef struct {
    logic re, we, hit, vd, br, rs;
    logic [10:0] exp;
  } vec_t;
  typedef struct {
    int          idx;
    logic [10:0] exp;
  } sb_t;
  vec_t tbl[$];
  sb_t  sb[$];
  int checks = 0;
  int errors = 0;
  localparam logic [10:0] IDLE   = 11'b00000000000;
  localparam logic [10:0] ST_HIT = 11'b01011000000;
  localparam logic [10:0] MISS   = 11'b10000000000;
  function automatic logic [10:0] ex_wb(input logic [1:0] wc);
    return {9'b100000111, wc};
  endfunction
  function automatic logic [10:0] ex_fill(input logic br, input logic [1:0] wc);
    return {1'b1, br, 7'b1011001, wc};
  endfunction
  task automatic add(input logic re, we, hit, vd, br, rs, input logic [10:0] e);
    tbl.push_back('{re, we, hit, vd, br, rs, e});
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [10:0] got;
      e   = sb.pop_front();
      got = {bus.Stall, bus.CWE, bus.CacheSrc, bus.DirtyIn, bus.ValidIn, bus.BusRE,
             bus.BusWE, bus.UseVictimTag, bus.UseCounter, bus.WordCount};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL vec%0d got %b want %b", e.idx, got, e.exp);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n, fills;
    bus.MemRE = 0; bus.MemWE = 0; bus.Hit = 0; bus.VictimDirty = 0; bus.BusReady = 0;
    add(0, 0, 0, 0, 0, 1, IDLE);
    add(0, 0, 0, 0, 0, 0, IDLE);
    add(1, 0, 1, 0, 0, 0, IDLE);
    add(0, 1, 1, 0, 0, 0, ST_HIT);
    add(1, 1, 1, 1, 0, 0, ST_HIT);
    add(0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 0, 0, 1, 0, MISS);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 1, 0, ex_fill(1, 2'(i)));
    add(1, 0, 1, 0, 1, 0, IDLE);
    add(0, 1, 0, 1, 1, 0, MISS);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, ex_wb(2'(i)));
    for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, ex_fill(1, 2'(i)));
    add(0, 1, 1, 0, 1, 0, ST_HIT);
    add(1, 0, 0, 0, 1, 0, MISS);
    for (int i = 0; i < 8; i++) add(i < 3, 0, 0, 0, i[0], 0, ex_fill(i[0], 2'(i / 2)));
    add(1, 0, 1, 0, 0, 0, IDLE);
    add(0, 1, 0, 1, 1, 0, MISS);
    add(0, 1, 0, 1, 1, 0, ex_wb(0));
    add(0, 1, 0, 1, 1, 0, ex_wb(1));
    add(0, 1, 0, 1, 0, 0, ex_wb(2));
    add(0, 1, 0, 1, 0, 1, ex_wb(2));
    add(0, 0, 0, 0, 1, 0, IDLE);
    add(1, 0, 1, 0, 1, 0, IDLE);
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      {bus.MemRE, bus.MemWE, bus.Hit, bus.VictimDirty, bus.BusReady, rst} =
        {tbl[i].re, tbl[i].we, tbl[i].hit, tbl[i].vd, tbl[i].br, tbl[i].rs};
      sb.push_back('{i, tbl[i].exp});
      @(posedge clk); #1;
    end
    {bus.MemRE, bus.MemWE, bus.Hit, bus.VictimDirty, bus.BusReady} = 5'b01011;
    n = 0;
    fills = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.Stall) break;
      n++;
      if (bus.CWE) fills++;
      if (fills == 4) bus.Hit = 1;
    end
    check("dirty_stall_cycles", n, 9);
    check("dirty_fill_writes", fills, 4);
    check("dirty_store_done", {bus.CWE, bus.DirtyIn, bus.CacheSrc}, 3'b110);
    @(posedge clk); #1;
    {bus.MemRE, bus.MemWE, bus.Hit, bus.VictimDirty, bus.BusReady} = 5'b00000;
    @(negedge clk);
    check("final_idle", {bus.Stall, bus.BusRE, bus.BusWE, bus.WordCount}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
